bram_copy_engine: RTL
=====================

// Module: bram_copy_engine
// PURPOSE
//  Initiator/master for the true-dual-port BRAM: copies LEN words from SRC to DST inside one BRAM.
//  Reads go on port A. Writes go on port B.
//  Pipelined at 1 word/clk. Start/busy/done handshake toward the control logic.
//  Sits between control logic and BRAM ports (integrator ties wr_ena=0, rd_enb=0).
// PARAMETERS
//  DATA_WIDTH  16    BRAM word width
//  ADDR_WIDTH  10    BRAM address width
//  RAM_DEPTH   1024  words in BRAM; legal range check bound
// PORTS
//  clk         in   1             clock, rising edge
//  rst         in   1             asynchronous, active-high reset
//  start       in   1             1-clk request; sampled only in IDLE
//  src_addr    in   ADDR_WIDTH    first source word
//  dst_addr    in   ADDR_WIDTH    first destination word
//  len         in   ADDR_WIDTH+1  word count, 0..RAM_DEPTH
//  busy        out  1             copy in progress
//  done        out  1             1-clk pulse at job end (also on error)
//  err         out  1             1-clk pulse with done when job rejected
//  words_done  out  ADDR_WIDTH+1  count of write beats issued for current/last job
//  rd_ena      out  1             BRAM port A read enable
//  addra       out  ADDR_WIDTH    BRAM port A address
//  douta       in   DATA_WIDTH    BRAM port A data; 1-clk registered read latency
//  wr_enb      out  1             BRAM port B write enable
//  addrb       out  ADDR_WIDTH    BRAM port B address
//  dinb        out  DATA_WIDTH    BRAM port B write data
// BEHAVIOUR
//  - One clock (clk); reset rst is asynchronous and active-high.
//  - All outputs are registered.
//  - Reset values: busy=0, done=0, err=0, rd_ena=0, wr_enb=0, addra=0, addrb=0, dinb=0, words_done=0. State is IDLE.
//  - FSM states and transitions:
//    - IDLE->CHECK on start.
//    - CHECK->RUN if legal and len>0.
//    - CHECK->FIN if len==0, with no BRAM access and err=0.
//    - CHECK->FIN with err=1 if illegal.
//    - RUN->DRAIN after the last read is issued.
//    - DRAIN->FIN after the last write is issued.
//    - FIN->IDLE, pulsing done (plus err if set).
//  - Illegal job:
//    - src_addr+len > RAM_DEPTH or dst_addr+len > RAM_DEPTH (no wrap-around allowed).
//    - Or dst_addr > src_addr && dst_addr < src_addr+len (forward overlap would corrupt source).
//  - Legal overlap: dst_addr <= src_addr is legal. Writes always trail reads by 2 beats at a lower address, so the engine never drives the same address on both ports in one clk.
//  - Range arithmetic uses ADDR_WIDTH+2 bits; no truncation.
//  - Pipeline:
//    - Read k is issued in cycle t (rd_ena=1, addra=src+k).
//    - douta is valid in t+1 and is registered into dinb.
//    - Write k is issued in t+2 (wr_enb=1, addrb=dst+k).
//    - Latency from start to done = len+3 clk.
//  - busy is 1 from the cycle after start until done is 1 (inclusive).
//  - start while busy is ignored; no queueing.
//  - Job inputs are captured in CHECK.
//  - words_done increments per write beat, clears at job start, and holds after done.
//  - Reset mid-job: rd_ena and wr_enb drop immediately (async). Already-written words persist. No done pulse.
// CONFIGURATION
//  - Macro BRAM_COPY_FILL_EN, when defined:
//    - Adds ports fill_mode (in, 1) and fill_value (in, DATA_WIDTH), both sampled with start.
//    - A fill job writes fill_value to dst..dst+len-1 with rd_ena held 0.
//    - The src range and overlap checks are skipped; the dst range check still applies.
//    - Writes start 2 clk after CHECK, so latency is unchanged.
//  - When undefined: these ports do not exist; copy only.
// STRUCTURE
//  - Shared include bram_defs.vh: state encodings (IDLE, CHECK, RUN, DRAIN, FIN) and default width/depth localparams shared with bram_truedualport.
//  - One sub-module, bram_copy_range_check: registered legality check producing legal and zero_len, using 1 clk (the CHECK state).
//  - FSM, address counters and the data pipeline stay in the top level.
// TESTING
//  (bench instantiates bram_truedualport with mem[i]=i preloaded)
//  1. start src=0,dst=512,len=8 -> done at start+11; mem[512..519]=0..7; words_done=8; err=0.
//  2. start src=100,dst=98,len=16 (legal overlap) -> mem[98..113]=100..115; port addresses never equal in any clk.
//  3. start src=10,dst=12,len=8 (forward overlap) -> done+err pulse 2 clk after start; wr_enb and rd_ena never 1.
//  4. start src=1020,dst=0,len=8 (out of range) -> err; len=0 -> done without err and without access.
//  5. rst asserted mid-job after 5 writes, src=0,dst=512,len=32 -> wr_enb=0 same cycle; mem[512..516] written, 517 untouched; busy=0.
//  6. BRAM_COPY_FILL_EN: fill_mode=1,fill_value=16'hA5A5,dst=300,len=4 -> mem[300..303]=A5A5; rd_ena stays 0.

Source files
------------

// File: rtl/bram_copy_engine_pkg.sv
// Shared types and default geometry for the BRAM copy engine.
// Optional fill feature is selected with BRAM_COPY_FILL_EN.
package bram_copy_engine_pkg;

    localparam int unsigned DefDataWidth = 16;
    localparam int unsigned DefAddrWidth = 10;
    localparam int unsigned DefRamDepth  = 1024;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StRun,
        StDrain,
        StFin
    } state_e;

endpackage

// File: rtl/bram_copy_engine_if.sv
// Control handshake plus BRAM port A (read) / port B (write) signals of the copy engine.
// Fill-mode inputs exist only when BRAM_COPY_FILL_EN is defined.
interface bram_copy_engine_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] src_addr;
    logic [ADDR_WIDTH-1:0] dst_addr;
    logic [ADDR_WIDTH:0]   len;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [ADDR_WIDTH:0]   words_done;
    logic                  rd_ena;
    logic [ADDR_WIDTH-1:0] addra;
    logic [DATA_WIDTH-1:0] douta;
    logic                  wr_enb;
    logic [ADDR_WIDTH-1:0] addrb;
    logic [DATA_WIDTH-1:0] dinb;
`ifdef BRAM_COPY_FILL_EN
    logic                  fill_mode;
    logic [DATA_WIDTH-1:0] fill_value;

    modport master (
        input  start, src_addr, dst_addr, len, douta, fill_mode, fill_value,
        output busy, done, err, words_done, rd_ena, addra, wr_enb, addrb, dinb
    );
    modport slave (
        output start, src_addr, dst_addr, len, douta, fill_mode, fill_value,
        input  busy, done, err, words_done, rd_ena, addra, wr_enb, addrb, dinb
    );
`else
    modport master (
        input  start, src_addr, dst_addr, len, douta,
        output busy, done, err, words_done, rd_ena, addra, wr_enb, addrb, dinb
    );
    modport slave (
        output start, src_addr, dst_addr, len, douta,
        input  busy, done, err, words_done, rd_ena, addra, wr_enb, addrb, dinb
    );
`endif
endinterface

// File: rtl/bram_copy_engine_range_check.sv
// Registered job legality check: range bounds (no wrap) and forward-overlap rejection.
module bram_copy_range_check #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned RAM_DEPTH  = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sample_i,
    input  logic                  fill_i,
    input  logic [ADDR_WIDTH-1:0] src_i,
    input  logic [ADDR_WIDTH-1:0] dst_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    output logic                  legal_o,
    output logic                  zero_len_o
);
    localparam int unsigned W = ADDR_WIDTH + 2;

    logic [W-1:0] src_w, dst_w, len_w, src_end, dst_end, depth_w;
    logic         legal_d, legal_q, zero_len_q;

    always_comb begin
        src_w   = {2'b00, src_i};
        dst_w   = {2'b00, dst_i};
        len_w   = {1'b0, len_i};
        depth_w = W'(RAM_DEPTH);
        src_end = src_w + len_w;
        dst_end = dst_w + len_w;
        // Fill jobs never read, so only the destination window matters.
        legal_d = (dst_end <= depth_w) &&
                  (fill_i || ((src_end <= depth_w) && !((dst_w > src_w) && (dst_w < src_end))));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            legal_q    <= 1'b0;
            zero_len_q <= 1'b0;
        end else if (sample_i) begin
            legal_q    <= legal_d;
            zero_len_q <= (len_i == '0);
        end
    end

    assign legal_o    = legal_q;
    assign zero_len_o = zero_len_q;
endmodule

// File: rtl/bram_copy_engine.sv
// BRAM copy engine: reads on port A, writes on port B two beats later, 1 word/clk.
// Define BRAM_COPY_FILL_EN to add a fill mode that writes a constant without reading.
module bram_copy_engine
    import bram_copy_engine_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned RAM_DEPTH  = DefRamDepth
) (
    input  logic               clk,
    input  logic               rst,
    bram_copy_engine_if.master bus
);
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
    logic [ADDR_WIDTH:0]   len_q, len_d, rd_cnt_q, rd_cnt_d, words_done_q, words_done_d;
    logic                  issue_q, issue_d, v1_q, v1_d;
    logic                  rd_ena_q, rd_ena_d, wr_enb_q, wr_enb_d;
    logic [ADDR_WIDTH-1:0] addra_q, addra_d, addrb_q, addrb_d, wr_ptr_q, wr_ptr_d;
    logic [DATA_WIDTH-1:0] dinb_q, dinb_d;
    logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                  sample, legal, zero_len, fill_in, fill_job;
    logic [DATA_WIDTH-1:0] fill_data;

`ifdef BRAM_COPY_FILL_EN
    logic                  fill_q, fill_d;
    logic [DATA_WIDTH-1:0] fill_val_q, fill_val_d;
    assign fill_in   = bus.fill_mode;
    assign fill_job  = fill_q;
    assign fill_data = fill_val_q;
`else
    assign fill_in   = 1'b0;
    assign fill_job  = 1'b0;
    assign fill_data = '0;
`endif

    assign sample = (state_q == StIdle) && bus.start;

    bram_copy_range_check #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .RAM_DEPTH (RAM_DEPTH)
    ) u_range_check (
        .clk_i     (clk),
        .rst_i     (rst),
        .sample_i  (sample),
        .fill_i    (fill_in),
        .src_i     (bus.src_addr),
        .dst_i     (bus.dst_addr),
        .len_i     (bus.len),
        .legal_o   (legal),
        .zero_len_o(zero_len)
    );

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
        rd_cnt_d     = rd_cnt_q;
        words_done_d = words_done_q;
        addra_d      = addra_q;
        addrb_d      = addrb_q;
        wr_ptr_d     = wr_ptr_q;
        dinb_d       = dinb_q;
        issue_d      = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
`ifdef BRAM_COPY_FILL_EN
        fill_d       = fill_q;
        fill_val_d   = fill_val_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d      = StCheck;
                    src_d        = bus.src_addr;
                    dst_d        = bus.dst_addr;
                    len_d        = bus.len;
                    words_done_d = '0;
`ifdef BRAM_COPY_FILL_EN
                    fill_d       = bus.fill_mode;
                    fill_val_d   = bus.fill_value;
`endif
                end
            end
            StCheck: begin
                if (!legal) begin
                    state_d = StFin;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else if (zero_len) begin
                    state_d = StFin;
                    done_d  = 1'b1;
                end else begin
                    state_d  = StRun;
                    issue_d  = 1'b1;
                    addra_d  = src_q;
                    rd_cnt_d = {{ADDR_WIDTH{1'b0}}, 1'b1};
                    wr_ptr_d = dst_q;
                end
            end
            StRun: begin
                if (rd_cnt_q == len_q) begin
                    state_d = StDrain;
                end else begin
                    issue_d  = 1'b1;
                    addra_d  = addra_q + 1'b1;
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            StDrain: begin
                // v1_q here marks the final beat, whose write is registered this edge.
                if (v1_q) begin
                    state_d = StFin;
                    done_d  = 1'b1;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Write pipeline trails the read slot by two beats regardless of FSM state.
        v1_d     = issue_q;
        wr_enb_d = v1_q;
        if (v1_q) begin
            addrb_d      = wr_ptr_q;
            wr_ptr_d     = wr_ptr_q + 1'b1;
            dinb_d       = fill_job ? fill_data : bus.douta;
            words_done_d = words_done_q + 1'b1;
        end
        rd_ena_d = issue_d && !fill_job;
        busy_d   = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            rd_cnt_q     <= '0;
            words_done_q <= '0;
            issue_q      <= 1'b0;
            v1_q         <= 1'b0;
            rd_ena_q     <= 1'b0;
            wr_enb_q     <= 1'b0;
            addra_q      <= '0;
            addrb_q      <= '0;
            wr_ptr_q     <= '0;
            dinb_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef BRAM_COPY_FILL_EN
            fill_q       <= 1'b0;
            fill_val_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            len_q        <= len_d;
            rd_cnt_q     <= rd_cnt_d;
            words_done_q <= words_done_d;
            issue_q      <= issue_d;
            v1_q         <= v1_d;
            rd_ena_q     <= rd_ena_d;
            wr_enb_q     <= wr_enb_d;
            addra_q      <= addra_d;
            addrb_q      <= addrb_d;
            wr_ptr_q     <= wr_ptr_d;
            dinb_q       <= dinb_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
`ifdef BRAM_COPY_FILL_EN
            fill_q       <= fill_d;
            fill_val_q   <= fill_val_d;
`endif
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.words_done = words_done_q;
    assign bus.rd_ena     = rd_ena_q;
    assign bus.addra      = addra_q;
    assign bus.wr_enb     = wr_enb_q;
    assign bus.addrb      = addrb_q;
    assign bus.dinb       = dinb_q;
endmodule
